// File: rtl/game_pkg.sv
// Shared game types and constants: phase encoding, score/decoy sizing and screen geometry.
package game_pkg;

  localparam int SCORE_W    = 9;
  localparam int NUM_DECOYS = 6;
  localparam int SCREEN_W   = 640;
  localparam int SCREEN_H   = 480;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    LOST  = 3'd3,
    OVER  = 3'd4
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/game_sequencer_frame_timer.sv
// Saturating animate-strobe counter with clear; flags the term-th pulse and term-reached.
module frame_timer #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         tick,
  input  logic [W-1:0] term,
  output logic         done,
  output logic         reached
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)                      cnt <= '0;
    else if (clr)                 cnt <= '0;
    else if (tick && cnt != '1)   cnt <= cnt + 1'b1;
  end

  // done fires on the pulse that brings the count to term
  assign done    = tick && (cnt >= term - 1'b1);
  assign reached = (cnt >= term);

endmodule

// File: rtl/game_sequencer.sv
// Game flow controller: phases, score/lives/level, paddle/ball/decoy enables.
// Optional HISCORE_EN adds a high-score register loaded on entry to OVER.
module game_sequencer #(
  parameter int LIVES        = 3,
  parameter int SERVE_FRAMES = 60,
  parameter int LOST_FRAMES  = 90,
  parameter int OVER_FRAMES  = 180,
  parameter int LEVEL_STEP   = 10,
  parameter int NUM_DECOYS   = game_pkg::NUM_DECOYS,
  parameter int SCORE_W      = game_pkg::SCORE_W
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_animate,
  input  logic                  i_start,
  input  logic                  i_hit,
  input  logic                  i_miss,
  output logic [2:0]            o_state,
  output logic                  o_ball_hold,
  output logic                  o_paddle_en,
  output logic [NUM_DECOYS-1:0] o_decoy_en,
  output logic [SCORE_W-1:0]    o_score,
  output logic [2:0]            o_lives,
  output logic [2:0]            o_level,
  output logic                  o_over
`ifdef HISCORE_EN
  , output logic [SCORE_W-1:0]  o_hiscore
`endif
);
  import game_pkg::*;

  localparam int FW = $clog2(max3(SERVE_FRAMES, LOST_FRAMES, OVER_FRAMES)) + 1;
  localparam int SW = $clog2(LEVEL_STEP + 1);

  state_t                  state_q, state_d;
  logic [SCORE_W-1:0]      score_d;
  logic [2:0]              lives_d, level_d;
  logic [SW-1:0]           step_q, step_d;
  logic [NUM_DECOYS-1:0]   decoy_d;
  logic                    start_q, start_edge, live;
  logic                    t_done, t_reached, t_clr;
  logic [FW-1:0]           t_term;

  assign start_edge = i_start & ~start_q;
  assign t_clr      = (state_d != state_q);
  assign o_state    = state_q;

  always_comb begin
    t_term = '0;
    case (state_q)
      SERVE:   t_term = FW'(SERVE_FRAMES);
      LOST:    t_term = FW'(LOST_FRAMES);
      OVER:    t_term = FW'(OVER_FRAMES);
      default: t_term = '0;
    endcase
  end

  frame_timer #(.W(FW)) u_timer (
    .clk(i_clk), .rst(i_rst), .clr(t_clr), .tick(i_animate),
    .term(t_term), .done(t_done), .reached(t_reached)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= i_start;
    end
  end

  always_comb begin
    state_d = state_q;
    score_d = o_score;
    lives_d = o_lives;
    level_d = o_level;
    step_d  = step_q;
    case (state_q)
      IDLE, OVER: begin
        // OVER only honours a start once the minimum freeze has elapsed
        if (start_edge && (state_q == IDLE || t_reached)) begin
          state_d = SERVE;
          score_d = '0;
          level_d = '0;
          step_d  = '0;
          lives_d = 3'(LIVES);
        end
      end
      SERVE: if (t_done) state_d = PLAY;
      LOST:  if (t_done) state_d = SERVE;
      PLAY: begin
        if (i_miss) begin
          lives_d = o_lives - 3'd1;
          state_d = (o_lives == 3'd1) ? OVER : LOST;
        end else if (i_hit) begin
          if (o_score != '1) score_d = o_score + 1'b1;
          if (step_q == SW'(LEVEL_STEP - 1)) begin
            step_d = '0;
            if (o_level != 3'(NUM_DECOYS)) level_d = o_level + 3'd1;
          end else begin
            step_d = step_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Enables are registered from the next state so they change with o_state
  always_comb begin
    live = (state_d == SERVE) || (state_d == PLAY) || (state_d == LOST);
    for (int i = 0; i < NUM_DECOYS; i++) decoy_d[i] = live && (level_d > 3'(i));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_ball_hold <= 1'b1;
      o_paddle_en <= 1'b0;
      o_decoy_en  <= '0;
      o_score     <= '0;
      o_lives     <= 3'(LIVES);
      o_level     <= '0;
      o_over      <= 1'b0;
      step_q      <= '0;
    end else begin
      o_ball_hold <= (state_d != PLAY);
      o_paddle_en <= (state_d == SERVE) || (state_d == PLAY);
      o_decoy_en  <= decoy_d;
      o_score     <= score_d;
      o_lives     <= lives_d;
      o_level     <= level_d;
      o_over      <= (state_d == OVER);
      step_q      <= step_d;
    end
  end

`ifdef HISCORE_EN
  always_ff @(posedge i_clk) begin
    if (i_rst)
      o_hiscore <= '0;
    else if (state_d == OVER && state_q != OVER && o_score > o_hiscore)
      o_hiscore <= o_score;
  end
`endif

endmodule

// File: tb/tb_game_sequencer.sv
// Directed self-checking bench for game_sequencer; HISCORE_EN adds high-score checks.
module tb_game_sequencer;

  logic       i_clk = 1'b0;
  logic       i_rst, i_animate, i_start, i_hit, i_miss;
  logic [2:0] o_state, o_lives, o_level;
  logic       o_ball_hold, o_paddle_en, o_over;
  logic [5:0] o_decoy_en;
  logic [8:0] o_score;
`ifdef HISCORE_EN
  logic [8:0] o_hiscore;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 i_clk = ~i_clk;

  game_sequencer dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_animate(i_animate), .i_start(i_start),
    .i_hit(i_hit), .i_miss(i_miss), .o_state(o_state), .o_ball_hold(o_ball_hold),
    .o_paddle_en(o_paddle_en), .o_decoy_en(o_decoy_en), .o_score(o_score),
    .o_lives(o_lives), .o_level(o_level), .o_over(o_over)
`ifdef HISCORE_EN
    , .o_hiscore(o_hiscore)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic anim(input int n);
    i_animate = 1'b1; tick(n); i_animate = 1'b0;
  endtask

  task automatic hit(input int n);
    i_hit = 1'b1; tick(n); i_hit = 1'b0;
  endtask

  task automatic miss();
    i_miss = 1'b1; tick(1); i_miss = 1'b0;
  endtask

  task automatic start();
    i_start = 1'b1; tick(1); i_start = 1'b0; tick(1);
  endtask

  task automatic do_reset();
    i_rst = 1'b1; tick(2); i_rst = 1'b0;
  endtask

`ifdef HISCORE_EN
  // play one game from IDLE/OVER ending with the given score
  task automatic play_game(input int hits);
    start(); anim(60); hit(hits);
    miss(); anim(90); anim(60);
    miss(); anim(90); anim(60);
    miss();
  endtask
`endif

  initial begin
    i_rst = 1'b0; i_animate = 1'b0; i_start = 1'b0; i_hit = 1'b0; i_miss = 1'b0;
    do_reset();
    chk("rst_state",  32'(o_state), 0);
    chk("rst_hold",   32'(o_ball_hold), 1);
    chk("rst_paddle", 32'(o_paddle_en), 0);
    chk("rst_decoy",  32'(o_decoy_en), 0);
    chk("rst_score",  32'(o_score), 0);
    chk("rst_lives",  32'(o_lives), 3);
    chk("rst_level",  32'(o_level), 0);
    chk("rst_over",   32'(o_over), 0);

    // hits while idle are ignored
    hit(2);
    chk("idle_hit", 32'(o_score), 0);

    start();
    chk("serve_state",  32'(o_state), 1);
    chk("serve_hold",   32'(o_ball_hold), 1);
    chk("serve_paddle", 32'(o_paddle_en), 1);
    anim(59);
    chk("serve_59", 32'(o_state), 1);
    anim(1);
    chk("play_state", 32'(o_state), 2);
    chk("play_hold",  32'(o_ball_hold), 0);

    hit(25);
    chk("score_25", 32'(o_score), 25);
    chk("level_2",  32'(o_level), 2);
    chk("decoy_2",  32'(o_decoy_en), 3);

    i_hit = 1'b1; i_miss = 1'b1; tick(1); i_hit = 1'b0; i_miss = 1'b0;
    chk("hm_score",  32'(o_score), 25);
    chk("hm_lives",  32'(o_lives), 2);
    chk("hm_state",  32'(o_state), 3);
    chk("lost_pad",  32'(o_paddle_en), 0);
    chk("lost_dec",  32'(o_decoy_en), 3);
    hit(1);
    chk("lost_hit", 32'(o_score), 25);
    anim(89);
    chk("lost_89", 32'(o_state), 3);
    anim(1);
    chk("lost_to_serve", 32'(o_state), 1);
    chk("serve_decoy",   32'(o_decoy_en), 3);

    anim(60); miss();
    chk("miss2_lives", 32'(o_lives), 1);
    anim(90); anim(60); miss();
    chk("over_state", 32'(o_state), 4);
    chk("over_flag",  32'(o_over), 1);
    chk("over_decoy", 32'(o_decoy_en), 0);
    chk("over_lives", 32'(o_lives), 0);
    chk("over_hold",  32'(o_ball_hold), 1);

    anim(100); start();
    chk("over_100", 32'(o_state), 4);
    anim(79); start();
    chk("over_179", 32'(o_state), 4);
    anim(1); start();
    chk("restart_state", 32'(o_state), 1);
    chk("restart_score", 32'(o_score), 0);
    chk("restart_lives", 32'(o_lives), 3);
    chk("restart_level", 32'(o_level), 0);
    chk("restart_over",  32'(o_over), 0);

    anim(60); hit(515);
    chk("sat_score", 32'(o_score), 511);
    chk("sat_level", 32'(o_level), 6);
    chk("sat_decoy", 32'(o_decoy_en), 63);

    do_reset(); start(); anim(60); hit(40);
    chk("pre_rst_score", 32'(o_score), 40);
    i_rst = 1'b1; tick(1); i_rst = 1'b0;
    chk("mid_rst_state", 32'(o_state), 0);
    chk("mid_rst_score", 32'(o_score), 0);
    chk("mid_rst_lives", 32'(o_lives), 3);
    chk("mid_rst_hold",  32'(o_ball_hold), 1);

`ifdef HISCORE_EN
    chk("hi_rst", 32'(o_hiscore), 0);
    play_game(40);
    chk("hi_40", 32'(o_hiscore), 40);
    anim(180);
    play_game(12);
    chk("hi_keep", 32'(o_hiscore), 40);
    chk("hi_score12", 32'(o_score), 12);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
